// File: rtl/timer_ctrl.sv
// Programmable count timer with IDLE/RUN/DONE control, one-shot or auto-reload.
// Optional clock prescaler enabled by defining TIMER_CTRL_PRESCALE_EN.
module timer_ctrl #(
    parameter int COUNT_WIDTH = 8,
    parameter int PRESCALE    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   periodic,
    input  logic [COUNT_WIDTH-1:0] period,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   tick
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] period_lat;
    logic                   periodic_lat;
    logic                   step;

`ifdef TIMER_CTRL_PRESCALE_EN
    logic [7:0] presc;

    // A count step happens only on the last clock of each prescale window.
    assign step = (presc == 8'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (stop || start || state != RUN || step) begin
            presc <= '0;
        end else begin
            presc <= presc + 8'd1;
        end
    end
`else
    assign step = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            period_lat   <= '0;
            periodic_lat <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tick         <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (stop) begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                state        <= RUN;
                count        <= '0;
                period_lat   <= period;
                periodic_lat <= periodic;
                busy         <= 1'b1;
                done         <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (step) begin
                            if (count < period_lat) begin
                                count <= count + 1'b1;
                            end else if (periodic_lat) begin
                                count <= '0;
                                tick  <= 1'b1;
                            end else begin
                                // Terminal count of a one-shot: freeze count at period.
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                tick  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized and directed scoreboard bench for timer_ctrl (COUNT_WIDTH=3).
// The reference model tracks elapsed steps since start and derives outputs arithmetically.
module tb_timer_ctrl;

    localparam int CW = 3;
`ifdef TIMER_CTRL_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          periodic = 1'b0;
    logic [CW-1:0] period = '0;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic          tick;

    int checks = 0;
    int errors = 0;

    timer_ctrl #(.COUNT_WIDTH(CW), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
        .period(period), .count(count), .busy(busy), .done(done), .tick(tick)
    );

    always #5 clk = ~clk;

    // Expected {count, busy, done, tick} after each rising edge.
    logic [5:0] exp_q[$];

    // Reference model: mode 0 idle, 1 running, 2 finished.
    int mode = 0, steps = 0, ph = 0, lat_p = 0;
    bit lat_per = 0;

    task automatic push_expected(bit tk);
        logic [CW-1:0] c;
        if (mode == 0)      exp_q.push_back(6'b0);
        else if (mode == 1) begin
            c = CW'(steps % (lat_p + 1));
            exp_q.push_back({c, 1'b1, 1'b0, tk});
        end else begin
            c = CW'(lat_p);
            exp_q.push_back({c, 1'b0, 1'b1, tk});
        end
    endtask

    task automatic model_reset();
        mode = 0; steps = 0; ph = 0; lat_p = 0; lat_per = 0;
        push_expected(1'b0);
    endtask

    task automatic model_edge(bit s, bit st, bit pe, int pr);
        bit tk = 1'b0;
        if (st) begin
            mode = 0; steps = 0; ph = 0;
        end else if (s) begin
            mode = 1; steps = 0; ph = 0; lat_p = pr; lat_per = pe;
        end else if (mode == 1) begin
            if (ph == PS - 1) begin
                ph = 0;
                steps++;
                if (steps % (lat_p + 1) == 0) begin
                    tk = 1'b1;
                    if (!lat_per) mode = 2;
                end
            end else begin
                ph++;
            end
        end
        push_expected(tk);
    endtask

    task automatic cyc(bit s, bit st, bit pe, int pr);
        start = s; stop = st; periodic = pe; period = CW'(pr);
        @(posedge clk);
        model_edge(s, st, pe, pr);
        #1;
    endtask

    task automatic idle(int n, bit pe, int pr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, pe, pr);
    endtask

    task automatic check_now(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        logic [5:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({count, busy, done, tick} !== e) begin
                errors++;
                $display("FAIL outputs got count=%0d busy=%b done=%b tick=%b expected count=%0d busy=%b done=%b tick=%b at %0t",
                         count, busy, done, tick, e[5:3], e[2], e[1], e[0], $time);
            end
        end
    end

    initial begin
        @(posedge clk); model_reset(); #1;
        @(posedge clk); model_reset(); #1;
        rst = 1'b1;

        idle(2, 1'b0, 0);
        // One-shot, period 3.
        cyc(1'b1, 1'b0, 1'b0, 3);
        idle(6 * PS, 1'b0, 3);
        // Auto-reload, period 2.
        cyc(1'b1, 1'b0, 1'b1, 2);
        idle(10 * PS, 1'b1, 2);
        // Stop beats start in the same cycle.
        cyc(1'b1, 1'b1, 1'b1, 5);
        idle(2, 1'b0, 5);
        // Restart mid-run at count 5.
        cyc(1'b1, 1'b0, 1'b0, 7);
        idle(5 * PS, 1'b0, 7);
        cyc(1'b1, 1'b0, 1'b0, 7);
        idle(2, 1'b0, 7);
        // Period and mode changes during a run are ignored.
        cyc(1'b1, 1'b0, 1'b0, 7);
        idle(11 * PS, 1'b1, 1);
        // Period 0 ticks every step.
        cyc(1'b1, 1'b0, 1'b1, 0);
        idle(4 * PS, 1'b1, 0);
        cyc(1'b0, 1'b1, 1'b0, 0);

        // Asynchronous reset between edges at count 4.
        cyc(1'b1, 1'b0, 1'b0, 7);
        idle(4 * PS, 1'b0, 7);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_now("async_count", int'(count), 0);
        check_now("async_busy", int'(busy), 0);
        check_now("async_tick", int'(tick), 0);
        @(posedge clk); model_reset(); #1;
        rst = 1'b1;
        idle(2, 1'b0, 7);

        // Randomized traffic with inputs wandering every cycle.
        for (int i = 0; i < 400; i++) begin
            bit s, st, pe;
            int pr;
            st = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 9) == 0);
            pe = 1'($urandom_range(0, 1));
            pr = int'($urandom_range(0, 7));
            cyc(s, st, pe, pr);
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        check_now("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 8: width of period and count.
REQ-002 SHALL have parameter PRESCALE, default 4: clocks per count step, legal range 1..255; honoured only under TIMER_CTRL_PRESCALE_EN.
REQ-003 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: start or restart a run.
REQ-006 SHALL have port stop, input, 1: abort the run and return to IDLE.
REQ-007 SHALL have port periodic, input, 1: 1 = auto-reload, 0 = one-shot; latched at start.
REQ-008 SHALL have port period, input, COUNT_WIDTH: terminal count; latched at start.
REQ-009 SHALL have port count, output, COUNT_WIDTH: current count value.
REQ-010 SHALL have port busy, output, 1: high in RUN.
REQ-011 SHALL have port done, output, 1: high in DONE.
REQ-012 SHALL have port tick, output, 1: one-cycle pulse on each terminal count.

Function
REQ-013 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-014 SHALL handle start in any state as follows: next state RUN, count=0, period and periodic latched, prescale counter cleared.
REQ-015 SHALL handle stop in any state as follows: next state IDLE, count=0, prescale counter cleared.
REQ-016 SHALL give stop priority over start when both are high in the same cycle.
REQ-017 SHALL, on a RUN step cycle with count<latched period, increment count by 1.
REQ-018 SHALL, on a RUN step cycle with count==latched period and periodic=1, set count=0, stay in RUN, and assert tick in the next cycle.
REQ-019 SHALL, on a RUN step cycle with count==latched period and periodic=0, move to DONE, hold count at period, and assert tick in the next cycle.
REQ-020 SHALL make a run last period+1 steps; period=0 gives a tick every step.
REQ-021 SHALL ignore changes on period and periodic during RUN until the next start.
REQ-022 SHALL drive tick from a register, high for exactly one cycle per terminal event, and never high in IDLE after stop.
REQ-023 SHALL hold count and stay in DONE until start or stop.
REQ-024 SHALL hold count at 0 in IDLE.
REQ-025 SHALL drive busy and done as registered state decodes, mutually exclusive.
REQ-026 SHALL never let count exceed the latched period; wrap occurs only through the REQ-018 reload.

Reset
REQ-027 SHALL, while rst=0, force the state to IDLE, count=0, latched period=0, latched periodic=0, prescale counter=0, and busy=done=tick=0, independent of clk.
REQ-028 SHALL, on reset assertion mid-run, abort immediately with no tick.
REQ-029 SHALL leave IDLE only on a start sampled at a rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with TIMER_CTRL_PRESCALE_EN defined, make a step cycle occur once every PRESCALE clocks in RUN: the prescale counter counts 0..PRESCALE-1 and the step occurs at PRESCALE-1.
REQ-031 SHALL, with TIMER_CTRL_PRESCALE_EN undefined, make every RUN clock a step cycle, exclude prescale logic, and ignore PRESCALE.

Verification (COUNT_WIDTH=3; macro undefined unless stated)
REQ-032 SHALL verify one-shot: period=3, periodic=0, one-cycle start -> count 0,1,2,3 on the following cycles, DONE with count=3, tick high exactly once, busy high for 4 cycles.
REQ-033 SHALL verify periodic: period=2, periodic=1 -> count 0,1,2,0,1,2..., with a tick every 3 cycles and busy held high.
REQ-034 SHALL verify priority and restart: start with stop in the same cycle -> IDLE, count=0; start at count=5 with period=7 -> count=0 next cycle, no tick.
REQ-035 SHALL verify latching: period changed from 7 to 1 mid-run -> the run still terminates at count=7.
REQ-036 SHALL verify asynchronous reset: rst pulled low between edges at count=4 -> count=0 and busy=0 immediately, with no tick.
REQ-037 SHALL verify the prescaler: macro defined, PRESCALE=4, period=1, one-shot -> count changes every 4 clocks and tick arrives 8 clocks after start.
